// File: rtl/smg_pkg.sv
// smg_pkg: shared types, constants and glyph lookup for the seven-segment
// scan controller and its 74HC595 serializer.
package smg_pkg;

    // Scan controller states.
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2,
        ST_WAIT  = 2'd3
    } scan_state_e;

    // Serializer phases: shcp low half, shcp high half, storage latch pulse.
    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_LOW   = 2'd1,
        PH_HIGH  = 2'd2,
        PH_LATCH = 2'd3
    } shift_phase_e;

    localparam int         WORD_W      = 16;
    localparam logic [7:0] SEL_ALL_OFF = 8'hFF;
    localparam logic [7:0] SEG_ALL_OFF = 8'hFF;

    // Active-low segment pattern {dp,g,f,e,d,c,b,a}; dp is off in the table.
    function automatic logic [7:0] glyph(input logic [3:0] v);
        logic [7:0] g;
        g = SEG_ALL_OFF;
        case (v)
            4'h0: g = 8'hC0;
            4'h1: g = 8'hF9;
            4'h2: g = 8'hA4;
            4'h3: g = 8'hB0;
            4'h4: g = 8'h99;
            4'h5: g = 8'h92;
            4'h6: g = 8'h82;
            4'h7: g = 8'hF8;
            4'h8: g = 8'h80;
            4'h9: g = 8'h90;
            4'hA: g = 8'h88;
            4'hB: g = 8'h83;
            4'hC: g = 8'hC6;
            4'hD: g = 8'hA1;
            4'hE: g = 8'h86;
            4'hF: g = 8'h8E;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/smg_scan_ctrl_if.sv
// smg_scan_ctrl_if: three-wire serial bus to the chained 74HC595 pair.
interface smg_scan_ctrl_if;
    logic ds_data;
    logic ds_shcp;
    logic ds_stcp;

    modport master (output ds_data, output ds_shcp, output ds_stcp);
    modport slave  (input  ds_data, input  ds_shcp, input  ds_stcp);
endinterface

// File: rtl/smg_scan_ctrl_hc595_shifter.sv
// hc595_shifter: shifts one 16-bit word MSB first into a 74HC595 chain and
// then pulses the storage latch. A start pulse always restarts from bit 15.
module hc595_shifter
    import smg_pkg::*;
#(
    parameter int SHCP_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [WORD_W-1:0] word_i,
    output logic              latch_o,
    output logic              done_o,
    smg_scan_ctrl_if.master   ds
);

    localparam int              DIV_W    = (SHCP_DIV > 1) ? $clog2(SHCP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SHCP_DIV - 1);

    shift_phase_e      ph_q, ph_d;
    logic [WORD_W-1:0] sh_q, sh_d;      // sh_q[MSB] is the bit on ds_data
    logic [3:0]        bit_q, bit_d;    // bits still to clock after the current one
    logic [DIV_W-1:0]  div_q, div_d;
    logic              shcp_q, shcp_d;
    logic              stcp_q, stcp_d;
    logic              done_q, done_d;
    logic              div_end;

    assign div_end = (div_q == DIV_LAST);

    // Phase and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q   <= PH_IDLE;
            sh_q   <= '0;
            bit_q  <= '0;
            div_q  <= '0;
            shcp_q <= 1'b0;
            stcp_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            ph_q   <= ph_d;
            sh_q   <= sh_d;
            bit_q  <= bit_d;
            div_q  <= div_d;
            shcp_q <= shcp_d;
            stcp_q <= stcp_d;
            done_q <= done_d;
        end
    end

    // Data moves only on the shcp falling edge, so it is stable while shcp is high.
    always_comb begin
        ph_d   = ph_q;
        sh_d   = sh_q;
        bit_d  = bit_q;
        div_d  = div_q;
        shcp_d = shcp_q;
        stcp_d = stcp_q;
        done_d = 1'b0;
        case (ph_q)
            PH_LOW: begin
                div_d = div_end ? '0 : div_q + 1'b1;
                if (div_end) begin
                    shcp_d = 1'b1;
                    ph_d   = PH_HIGH;
                end
            end
            PH_HIGH: begin
                div_d = div_end ? '0 : div_q + 1'b1;
                if (div_end) begin
                    shcp_d = 1'b0;
                    if (bit_q == 4'd0) begin
                        stcp_d = 1'b1;
                        ph_d   = PH_LATCH;
                    end else begin
                        sh_d  = {sh_q[WORD_W-2:0], 1'b0};
                        bit_d = bit_q - 4'd1;
                        ph_d  = PH_LOW;
                    end
                end
            end
            PH_LATCH: begin
                div_d = div_end ? '0 : div_q + 1'b1;
                if (div_end) begin
                    stcp_d = 1'b0;
                    done_d = 1'b1;
                    ph_d   = PH_IDLE;
                end
            end
            default: ;
        endcase
        if (start_i) begin
            sh_d   = word_i;
            bit_d  = 4'd15;
            div_d  = '0;
            shcp_d = 1'b0;
            stcp_d = 1'b0;
            ph_d   = PH_LOW;
        end
    end

    assign latch_o    = (ph_q == PH_LATCH);
    assign done_o     = done_q;
    assign ds.ds_data = sh_q[WORD_W-1];
    assign ds.ds_shcp = shcp_q;
    assign ds.ds_stcp = stcp_q;

endmodule

// File: rtl/smg_scan_ctrl.sv
// smg_scan_ctrl: eight-digit seven-segment scan scheduler. Holds a shadow of
// the digit values, dwells SCAN_CNT cycles per digit and hands each
// {segment, select} word to the 74HC595 serializer.
// Build option: define SMG_LZB_EN for leading-zero blanking.
module smg_scan_ctrl
    import smg_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int SCAN_CNT = 50000,
    parameter int SHCP_DIV = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*DIGITS-1:0] din_i,
    input  logic                din_vld_i,
    input  logic [DIGITS-1:0]   dp_mask_i,
    output logic                busy_o,
    output logic                frame_done_o,
    smg_scan_ctrl_if.master     ds
);

    localparam int               CNT_W    = $clog2(SCAN_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_CNT - 1);
    localparam logic [2:0]       IDX_LAST = 3'(DIGITS - 1);

    scan_state_e             state_q, state_d;
    logic [2:0]              idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic [DIGITS-1:0][3:0]  digit_q;
    logic [DIGITS-1:0]       dp_q;

    logic                    start;
    logic                    sh_latch;
    logic                    sh_done;
    logic [3:0]              cur_digit;
    logic [7:0]              seg;
    logic [7:0]              sel;
    logic [WORD_W-1:0]       word;

    // Shadow copy of the display contents; loadable in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= '0;
            dp_q    <= '0;
        end else if (din_vld_i) begin
            digit_q <= din_i;
            dp_q    <= dp_mask_i;
        end
    end

    // Scan state, digit index and free-running dwell counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Next state; the dwell wrap overrides everything so each digit lasts SCAN_CNT cycles.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        start   = 1'b0;
        cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        case (state_q)
            ST_LOAD: begin
                start   = 1'b1;
                busy_d  = 1'b1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: if (sh_latch) state_d = ST_LATCH;
            ST_LATCH: if (sh_done) begin
                state_d = ST_WAIT;
                busy_d  = 1'b0;
            end
            default: ;
        endcase
        if (cnt_q == CNT_LAST) begin
            state_d = ST_LOAD;
            idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end
    end

`ifdef SMG_LZB_EN
    logic upper_zero;

    // True when the current digit and every digit above it are zero.
    always_comb begin
        upper_zero = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (k >= int'(idx_q) && digit_q[k] != 4'h0) upper_zero = 1'b0;
        end
    end
`endif

    // Word for the current digit: active-low glyph with dp in bit 7, one-cold select.
    always_comb begin
        cur_digit = digit_q[idx_q];
        seg       = glyph(cur_digit) & {~dp_q[idx_q], 7'h7F};
`ifdef SMG_LZB_EN
        if (idx_q != 3'd0 && !dp_q[idx_q] && upper_zero) seg = SEG_ALL_OFF;
`endif
        sel  = SEL_ALL_OFF & ~(8'd1 << idx_q);
        word = {seg, sel};
    end

    hc595_shifter #(
        .SHCP_DIV (SHCP_DIV)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .word_i  (word),
        .latch_o (sh_latch),
        .done_o  (sh_done),
        .ds      (ds)
    );

    assign busy_o       = busy_q;
    assign frame_done_o = (state_q == ST_LATCH) && sh_done && (idx_q == IDX_LAST);

endmodule

// File: tb/tb_smg_scan_ctrl.sv
// tb_smg_scan_ctrl: table vectors, hand sequences and a randomized scan of
// smg_scan_ctrl, checked against a word-level model of the display.
module tb_smg_scan_ctrl;

    localparam int DIGITS   = 8;
    localparam int SCAN_CNT = 100;
    localparam int SHCP_DIV = 2;
    localparam int NV       = 10;
    localparam int LATCH_END = 1 + 32 * SHCP_DIV + SHCP_DIV;

    logic        clk;
    logic        rst;
    logic [31:0] din;
    logic        din_vld;
    logic [7:0]  dp_mask;
    logic        busy;
    logic        frame_done;

    smg_scan_ctrl_if ds ();

    smg_scan_ctrl #(
        .DIGITS   (DIGITS),
        .SCAN_CNT (SCAN_CNT),
        .SHCP_DIV (SHCP_DIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .din_i        (din),
        .din_vld_i    (din_vld),
        .dp_mask_i    (dp_mask),
        .busy_o       (busy),
        .frame_done_o (frame_done),
        .ds           (ds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;   // edges since reset release

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct { int c; logic [31:0] d; logic [7:0] m; } upd_t;
    typedef struct { logic [31:0] din; logic [7:0] dp; int idx; logic [15:0] exp; } vec_t;

    upd_t        upd[$];
    logic [15:0] words[$];
    vec_t        tab[NV];

    logic [7:0] gtab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Word n after reset is loaded at edge n*SCAN_CNT+1 from shadow updates captured strictly earlier.
    function automatic logic [15:0] model_word(input int n);
        int          idx  = n % DIGITS;
        int          load = n * SCAN_CNT + 1;
        logic [31:0] sh   = 32'h0;
        logic [7:0]  m    = 8'h0;
        logic [3:0]  dig;
        logic [7:0]  seg;
        foreach (upd[i]) if (upd[i].c < load) begin
            sh = upd[i].d;
            m  = upd[i].m;
        end
        dig = 4'((sh >> (4 * idx)) & 32'hF);
        seg = gtab[dig];
        if (m[idx]) seg = seg & 8'h7F;
`ifdef SMG_LZB_EN
        if (idx != 0 && !m[idx] && (sh >> (4 * idx)) == 32'h0) seg = 8'hFF;
`endif
        return {seg, 8'hFF ^ (8'd1 << idx)};
    endfunction

    // Bus monitor: rebuilds shifted words and checks bus timing.
    int ovl = 0, dviol = 0, fdw = 0;
    initial begin
        logic        ps, pt, pd, pf;
        logic [15:0] sreg;
        int          nbits, nwords, last_rise, stcp_w, last_fd;
        ps = 0; pt = 0; pd = 0; pf = 0; sreg = 0;
        nbits = 0; nwords = 0; last_rise = 0; stcp_w = 0; last_fd = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                nbits = 0; nwords = 0; stcp_w = 0; last_fd = 0;
                words.delete();
                ps = 0; pt = 0; pd = 0; pf = 0;
            end else begin
                if (ds.ds_shcp && ds.ds_stcp) ovl++;
                if (ps && ds.ds_shcp && ds.ds_data !== pd) dviol++;
                if (ds.ds_shcp && !ps) begin
                    if (nbits == 0) chk("shcp_first_rise", cyc, nwords * SCAN_CNT + 1 + SHCP_DIV);
                    else            chk("shcp_spacing", cyc - last_rise, 2 * SHCP_DIV);
                    last_rise = cyc;
                    sreg = {sreg[14:0], ds.ds_data};
                    nbits++;
                end
                if (ds.ds_stcp && !pt) begin
                    chk("bits_per_word", nbits, 16);
                    chk($sformatf("word%0d", nwords), sreg, model_word(nwords));
                    words.push_back(sreg);
                    nwords++;
                    nbits  = 0;
                    stcp_w = 0;
                end
                if (ds.ds_stcp) stcp_w++;
                if (!ds.ds_stcp && pt) chk("stcp_width", stcp_w, SHCP_DIV);
                if (frame_done && !pf) begin
                    if (last_fd == 0) chk("frame_done_first", cyc, (DIGITS - 1) * SCAN_CNT + LATCH_END);
                    else              chk("frame_done_period", cyc - last_fd, DIGITS * SCAN_CNT);
                    last_fd = cyc;
                end
                if (frame_done && pf) fdw++;
                ps = ds.ds_shcp; pt = ds.ds_stcp; pd = ds.ds_data; pf = frame_done;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        din_vld = 1'b0;
        upd.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < 20000 && cyc < n; i++) @(negedge clk);
    endtask

    // Called at a negedge; the strobe is captured at the following edge.
    task automatic drive_din(input logic [31:0] d, input logic [7:0] m);
        din = d; dp_mask = m; din_vld = 1'b1;
        upd.push_back('{cyc + 1, d, m});
        @(negedge clk);
        din_vld = 1'b0;
    endtask

    task automatic wait_word(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < (n + 3) * SCAN_CNT; i++) begin
            if (words.size() > n) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit          ok;
        int          bc, n;
        logic [31:0] d;
        logic [7:0]  m;

        tab[0] = '{32'h12345678, 8'h00, 0, 16'h80FE};
        tab[1] = '{32'h12345678, 8'h00, 7, 16'hF97F};
        tab[2] = '{32'h12345678, 8'h01, 0, 16'h00FE};
        tab[3] = '{32'hFEDCBA90, 8'h00, 1, 16'h90FD};
        tab[4] = '{32'hFEDCBA90, 8'h00, 6, 16'h86BF};
        tab[5] = '{32'h0000A000, 8'h08, 3, 16'h08F7};
`ifdef SMG_LZB_EN
        tab[6] = '{32'h00000305, 8'h00, 7, 16'hFF7F};
        tab[7] = '{32'h00000305, 8'h00, 3, 16'hFFF7};
`else
        tab[6] = '{32'h00000305, 8'h00, 7, 16'hC07F};
        tab[7] = '{32'h00000305, 8'h00, 3, 16'hC0F7};
`endif
        tab[8] = '{32'h00000305, 8'h80, 7, 16'h407F};
        tab[9] = '{32'h00000305, 8'h00, 2, 16'hB0FB};

        rst = 1'b1; din = '0; din_vld = 1'b0; dp_mask = '0;

        // Reset state, then first word straight after release.
        repeat (3) @(negedge clk);
        chk("rst_ds_data", ds.ds_data, 0);
        chk("rst_ds_shcp", ds.ds_shcp, 0);
        chk("rst_ds_stcp", ds.ds_stcp, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        rst = 1'b0;
        bc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy) bc++;
            else break;
        end
        chk("busy_cycles", bc, LATCH_END);
        wait_word(0, ok);
        chk("first_word", ok ? 32'(words[0]) : 32'hDEAD, 32'hC0FE);

        // Table vectors: load din, then check the word of the chosen digit.
        for (int t = 0; t < NV; t++) begin
            do_reset();
            wait_cyc(2);
            drive_din(tab[t].din, tab[t].dp);
            n = (tab[t].idx == 0) ? DIGITS : tab[t].idx;
            wait_word(n, ok);
            chk($sformatf("tab%0d_word", t), ok ? 32'(words[n]) : 32'hDEAD, 32'(tab[t].exp));
        end

        // din_vld coinciding with the LOAD of digit 1.
        do_reset();
        wait_cyc(SCAN_CNT);
        drive_din(32'h88888888, 8'h00);
        wait_word(2, ok);
        chk("load_coincide_old", ok ? 32'(words[1]) : 32'hDEAD, 32'hC0FD);
        chk("load_coincide_new", ok ? 32'(words[2]) : 32'hDEAD, 32'h80FB);

        // Reset asserted mid-shift while shcp and data are both high.
        do_reset();
        wait_cyc(3);
        chk("pre_reset_shcp_data", {ds.ds_shcp, ds.ds_data}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_shcp", ds.ds_shcp, 0);
        chk("midrst_stcp", ds.ds_stcp, 0);
        chk("midrst_data", ds.ds_data, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        upd.delete();
        wait_word(0, ok);
        chk("midrst_word0", ok ? 32'(words[0]) : 32'hDEAD, 32'hC0FE);

        // Randomized scan over three frames against the model.
        do_reset();
        for (int c = 0; c < 3 * DIGITS * SCAN_CNT + 200; c++) begin
            @(negedge clk);
            din_vld = 1'b0;
            if ($urandom_range(0, 59) == 0) begin
                d = $urandom >> (4 * $urandom_range(0, 7));
                m = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255)) : 8'h00;
                din = d; dp_mask = m; din_vld = 1'b1;
                upd.push_back('{cyc + 1, d, m});
            end
        end
        @(negedge clk);
        din_vld = 1'b0;
        chk("scan_word_count", words.size() >= 3 * DIGITS, 1);

        chk("shcp_stcp_overlap", ovl, 0);
        chk("data_change_while_shcp_high", dviol, 0);
        chk("frame_done_width", fdw, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
